// File: rtl/demux_reader16.sv
// demux_reader16: sweeps a 16:1 upstream mux through indices 0..15, waits
// SETTLE cycles after each select change, captures the active-low returned
// bit into a shadow word and publishes the whole word on Out at sweep end.
// The select lines always reflect the registered index, so the mux sees a
// stable address for the full settle and sample window of each bit.
module demux_reader16 #(
    parameter int unsigned SETTLE = 1    // wait cycles per select change, 0..7
) (
    input  logic        CLK,
    input  logic        RST_L,
    input  logic        Start,
    input  logic        Abort,
    input  logic        Y_L,
    output logic [1:0]  sel1,
    output logic [1:0]  sel2,
    output logic        Busy,
    output logic        Done,
    output logic [15:0] Out
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Last settle-counter value before sampling; unused when SETTLE is 0
    // because the SETTLE state is then never entered.
    localparam logic [2:0] SETTLE_LAST = (SETTLE == 0) ? 3'd0 : 3'(SETTLE - 1);

    // State entered after a select change: skip settling entirely when the
    // mux needs no settle time.
    localparam state_t ST_AFTER_SEL = (SETTLE == 0) ? ST_SAMPLE : ST_SETTLE;

    state_t      state_q, state_d;
    logic [3:0]  index_q, index_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [15:0] shadow_q, shadow_d;
    logic [15:0] out_q, out_d;
    logic        sample_en;
    logic        load_out;

    // Next-state, index and settle-counter logic for the sweep sequencer.
    always_comb begin
        state_d   = state_q;
        index_d   = index_q;
        cnt_d     = cnt_q;
        sample_en = 1'b0;
        load_out  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // Abort has priority over a simultaneous Start.
                if (Start && !Abort) begin
                    index_d = 4'd0;
                    cnt_d   = 3'd0;
                    state_d = ST_AFTER_SEL;
                end
            end
            ST_SETTLE: begin
                if (Abort) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == SETTLE_LAST) begin
                    state_d = ST_SAMPLE;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            ST_SAMPLE: begin
                if (Abort) begin
                    // Abandon the sweep without touching shadow or Out.
                    state_d = ST_IDLE;
                end else begin
                    sample_en = 1'b1;
                    if (index_q == 4'd15) begin
                        load_out = 1'b1;
                        state_d  = ST_DONE;
                    end else begin
                        index_d = index_q + 4'd1;
                        cnt_d   = 3'd0;
                        state_d = ST_AFTER_SEL;
                    end
                end
            end
            ST_DONE: begin
                // Start and Abort are both ignored here; the cycle always
                // completes and returns to IDLE.
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Per-bit shadow capture: only the bit addressed by the current index is
    // written, and only in the SAMPLE state, so Y_L is ignored elsewhere.
    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_shadow
            assign shadow_d[gi] = (sample_en && (index_q == 4'(gi))) ? ~Y_L
                                                                     : shadow_q[gi];
        end
    endgenerate

    // Out is loaded on the edge that enters DONE, using the shadow word that
    // already includes bit 15, so the new word is valid while Done is high.
    assign out_d = load_out ? shadow_d : out_q;

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge CLK or negedge RST_L) begin
        if (!RST_L) begin
            state_q  <= ST_IDLE;
            index_q  <= 4'd0;
            cnt_q    <= 3'd0;
            shadow_q <= 16'h0000;
            out_q    <= 16'h0000;
        end else begin
            state_q  <= state_d;
            index_q  <= index_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            out_q    <= out_d;
        end
    end

    // Outputs decoded directly from registered state so reset forces them
    // immediately.
    assign sel2 = index_q[3:2];
    assign sel1 = index_q[1:0];
    assign Busy = (state_q == ST_SETTLE) || (state_q == ST_SAMPLE);
    assign Done = (state_q == ST_DONE);
    assign Out  = out_q;

endmodule

// File: tb/tb_demux_reader16.sv
// Testbench for demux_reader16: unit 0 built with SETTLE=1, unit 1 with
// SETTLE=0. Each unit sees a 16:1 mux model returning ~W[{sel2,sel1}];
// during non-sampling cycles the model returns the wrong bit on purpose.
module tb_demux_reader16;

    logic        clk;
    logic        rst_n;
    logic        start_r [2];
    logic        abort_r [2];
    logic        noise_r [2];
    logic [15:0] w_r     [2];
    logic        y_l_w   [2];
    logic [1:0]  sel1_w  [2];
    logic [1:0]  sel2_w  [2];
    logic        busy_w  [2];
    logic        done_w  [2];
    logic [15:0] out_w   [2];

    int n_checks;
    int n_fail;

    demux_reader16 #(.SETTLE(1)) u_dut_s1 (
        .CLK   (clk),
        .RST_L (rst_n),
        .Start (start_r[0]),
        .Abort (abort_r[0]),
        .Y_L   (y_l_w[0]),
        .sel1  (sel1_w[0]),
        .sel2  (sel2_w[0]),
        .Busy  (busy_w[0]),
        .Done  (done_w[0]),
        .Out   (out_w[0])
    );

    demux_reader16 #(.SETTLE(0)) u_dut_s0 (
        .CLK   (clk),
        .RST_L (rst_n),
        .Start (start_r[1]),
        .Abort (abort_r[1]),
        .Y_L   (y_l_w[1]),
        .sel1  (sel1_w[1]),
        .sel2  (sel2_w[1]),
        .Busy  (busy_w[1]),
        .Done  (done_w[1]),
        .Out   (out_w[1])
    );

    // Mux model: correct active-low bit, or the opposite bit when noisy.
    assign y_l_w[0] = noise_r[0] ? w_r[0][{sel2_w[0], sel1_w[0]}] : ~w_r[0][{sel2_w[0], sel1_w[0]}];
    assign y_l_w[1] = noise_r[1] ? w_r[1][{sel2_w[1], sel1_w[1]}] : ~w_r[1][{sel2_w[1], sel1_w[1]}];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outs(input int u, input string tag, input logic [3:0] idx,
                              input logic busy, input logic done, input logic [15:0] out);
        check({tag, "_sel"},  {28'd0, sel2_w[u], sel1_w[u]}, {28'd0, idx});
        check({tag, "_busy"}, {31'd0, busy_w[u]}, {31'd0, busy});
        check({tag, "_done"}, {31'd0, done_w[u]}, {31'd0, done});
        check({tag, "_out"},  {16'd0, out_w[u]},  {16'd0, out});
    endtask

    // Pulse Start from IDLE; returns 1 time unit after the accepting edge.
    task automatic kick(input int u, input logic [15:0] w);
        @(negedge clk);
        w_r[u]     = w;
        noise_r[u] = 1'b1;
        start_r[u] = 1'b1;
        @(posedge clk);
        #1;
        start_r[u] = 1'b0;
    endtask

    // Follow a sweep from the accepting edge (j=0) to DONE (j=D) and check
    // every cycle. Optionally re-pulse Start at cycle repulse_j, or leave
    // Start high from the DONE cycle on (caller then handles the restart).
    task automatic observe(input int u, input int s, input logic [15:0] exp_out,
                           input logic [15:0] prev_out, input int repulse_j,
                           input bit start_at_done, input string tag);
        int d;
        d = 16 * (s + 1);
        for (int j = 0; j <= d; j++) begin
            if (j > 0) begin
                @(posedge clk);
                #1;
            end
            noise_r[u] = !((j < d) && ((j % (s + 1)) == s));
            start_r[u] = (j == repulse_j) || (start_at_done && (j == d));
            if (j < d)
                check_outs(u, $sformatf("%s_j%0d", tag, j), 4'(j / (s + 1)), 1'b1, 1'b0, prev_out);
            else
                check_outs(u, $sformatf("%s_j%0d", tag, j), 4'd15, 1'b0, 1'b1, exp_out);
        end
        if (!start_at_done) begin
            @(posedge clk);
            #1;
            check_outs(u, {tag, "_idle"}, 4'd15, 1'b0, 1'b0, exp_out);
        end
        $display("sweep %s unit=%0d settle=%0d out=%h expected=%h", tag, u, s, out_w[u], exp_out);
    endtask

    // Advance one cycle inside a sweep, keeping the mux noisy outside SAMPLE.
    task automatic step(input int u, input int s, input int j);
        @(posedge clk);
        #1;
        noise_r[u] = !((j % (s + 1)) == s);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b1;
        for (int u = 0; u < 2; u++) begin
            start_r[u] = 1'b0;
            abort_r[u] = 1'b0;
            noise_r[u] = 1'b0;
            w_r[u]     = 16'h0000;
        end

        // Asynchronous reset before any clock edge.
        #2 rst_n = 1'b0;
        #1;
        check_outs(0, "reset_u0", 4'd0, 1'b0, 1'b0, 16'h0000);
        check("reset_u1_out", {16'd0, out_w[1]}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

        // Outputs hold reset values while idle, whatever Y_L does.
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            noise_r[0] = 1'($urandom);
            check_outs(0, $sformatf("postreset_%0d", k), 4'd0, 1'b0, 1'b0, 16'h0000);
        end
        $display("idle after reset out=%h", out_w[0]);

        // Basic sweep, SETTLE=1: Done in cycle 33.
        kick(0, 16'h4B3C);
        observe(0, 1, 16'h4B3C, 16'h0000, -1, 1'b0, "basic");

        // Back-to-back: Start held from DONE; accepted only from IDLE.
        kick(0, 16'hFFFC);
        observe(0, 1, 16'hFFFC, 16'h4B3C, -1, 1'b1, "b2b_first");
        @(posedge clk);
        #1;
        check_outs(0, "b2b_idle", 4'd15, 1'b0, 1'b0, 16'hFFFC);
        @(posedge clk);
        #1;
        start_r[0] = 1'b0;
        observe(0, 1, 16'hFFFC, 16'hFFFC, -1, 1'b0, "b2b_second");

        // Restore Out=4B3C, then abort at index 7.
        kick(0, 16'h4B3C);
        observe(0, 1, 16'h4B3C, 16'hFFFC, -1, 1'b0, "restore");
        kick(0, 16'h1234);
        for (int j = 1; j <= 14; j++) step(0, 1, j);
        check("abort_at_idx", {28'd0, sel2_w[0], sel1_w[0]}, 32'd7);
        abort_r[0] = 1'b1;
        @(posedge clk);
        #1;
        abort_r[0] = 1'b0;
        check("abort_busy", {31'd0, busy_w[0]}, 32'd0);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("abort_done_%0d", k), {31'd0, done_w[0]}, 32'd0);
            check($sformatf("abort_out_%0d", k), {16'd0, out_w[0]}, 32'h4B3C);
            @(posedge clk);
            #1;
        end
        $display("abort at index 7 out=%h expected=4b3c", out_w[0]);

        // Abort and Start together in IDLE: stay idle.
        @(negedge clk);
        start_r[0] = 1'b1;
        abort_r[0] = 1'b1;
        @(posedge clk);
        #1;
        start_r[0] = 1'b0;
        abort_r[0] = 1'b0;
        check("abort_start_busy0", {31'd0, busy_w[0]}, 32'd0);
        @(posedge clk);
        #1;
        check("abort_start_busy1", {31'd0, busy_w[0]}, 32'd0);
        check("abort_start_done", {31'd0, done_w[0]}, 32'd0);
        $display("abort+start in idle busy=%0b", busy_w[0]);

        // Start re-pulsed at index 5 is ignored.
        kick(0, 16'h1234);
        observe(0, 1, 16'h1234, 16'h4B3C, 10, 1'b0, "repulse");

        // SETTLE=0 unit: one sample per cycle, Done in cycle 17.
        kick(1, 16'hA5A5);
        observe(1, 0, 16'hA5A5, 16'h0000, -1, 1'b0, "settle0");

        // Reset asserted at index 10 mid-sweep, then a normal sweep.
        kick(0, 16'h1234);
        for (int j = 1; j <= 20; j++) step(0, 1, j);
        check("rst_mid_idx", {28'd0, sel2_w[0], sel1_w[0]}, 32'd10);
        #1 rst_n = 1'b0;
        #1;
        check_outs(0, "rst_mid", 4'd0, 1'b0, 1'b0, 16'h0000);
        @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_outs(0, "rst_release", 4'd0, 1'b0, 1'b0, 16'h0000);
        kick(0, 16'h1234);
        observe(0, 1, 16'h1234, 16'h0000, -1, 1'b0, "after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
